mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the LoongArch CPU. It sits between the execute stage and `wb_stage` and transmits into the write-back stage's `ms_to_ws_valid` / `ws_allowin` handshake. It latches execute-stage results and waits for the data-SRAM response on loads. It aligns and sign/zero-extends load data, forwards the write-back candidate to decode, and discards in-flight responses when write-back flushes the pipe.

## Interface
- `ES_W`, default 157: width of `es_to_ms_bus`.
- `MS_W`, default 152: width of `ms_to_ws_bus`.
- `clk` in 1: clock. Reset is `reset`, synchronous, active-high.
- `reset` in 1: synchronous, active-high.
- `es_to_ms_valid` in 1: execute stage holds a valid instruction.
- `ms_allowin` out 1: this stage accepts an instruction this cycle.
- `es_to_ms_bus` in ES_W: fields from MSB to LSB:
  - `csr_f[81:0]`, which is {csr_wvalue[31:0], ertn, syscall, csr_re, csr_we, csr_num[13:0], csr_wmask[31:0]}.
  - `req_issued`: the data-SRAM request was already accepted in execute.
  - `mem_sign`.
  - `mem_size[1:0]`: 0 = byte, 1 = half, 2 = word.
  - `res_from_mem`, `gr_we`, `dest[4:0]`, `alu_result[31:0]`, `pc[31:0]`.
- `data_sram_data_ok` in 1: one-cycle pulse carrying a read/write response.
- `data_sram_rdata` in 32: response data, valid with `data_ok`.
- `ws_allowin` in 1: write-back stage accepts.
- `ms_to_ws_valid` out 1.
- `ms_to_ws_bus` out MS_W: {csr_f[81:0], gr_we, dest[4:0], final_result[31:0], pc[31:0]}.
- `ms_to_ds_fwd` out 39: {fwd_we, fwd_dest[4:0], fwd_block, fwd_data[31:0]}.
- `ws_flush_pipe` in 1: exception or ertn committed in write-back.

## Operation
- The stage register `ms_bus_r` loads on `es_to_ms_valid && ms_allowin && !ws_flush_pipe`.
- Valid register update:
  - `ms_valid <= 0` on reset or on `ws_flush_pipe`.
  - Otherwise, when `ms_allowin`, `ms_valid <= es_to_ms_valid`.
- `need_resp = ms_valid && req_issued`. Stores with `req_issued` also wait for their response.
- Response FSM:
  - **IDLE**: no response pending.
    - New instruction accepted with `req_issued` and no `data_ok` in the same cycle → WAIT.
    - `data_ok` arriving the same cycle the instruction is loaded is not possible; execute guarantees it.
  - **WAIT**:
    - `data_ok` && `ws_allowin` → IDLE, instruction passes.
    - `data_ok` && !`ws_allowin` → HELD, with `rdata_buf <= data_sram_rdata`.
    - `ws_flush_pipe` without `data_ok` → DISCARD.
    - `ws_flush_pipe` with `data_ok` → IDLE, response dropped.
  - **HELD**:
    - `ws_allowin` → IDLE.
    - `ws_flush_pipe` → IDLE.
  - **DISCARD**: the next `data_ok` is dropped, then → IDLE.
- `ms_ready_go = !need_resp || (state==WAIT && data_ok) || state==HELD`.
- `ms_allowin = (state!=DISCARD) && (!ms_valid || (ms_ready_go && ws_allowin))`.
- `ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe`.
- Load data source is `rdata_buf` in HELD, else `data_sram_rdata`. Let `off = alu_result[1:0]`:
  - Byte: `rdata[8*off+7 : 8*off]`.
  - Half: `rdata[16*off[1]+15 : 16*off[1]]`.
  - Word: whole word.
  - Extend to 32 bits with sign if `mem_sign`, else zero.
- `final_result = res_from_mem ? aligned_load : alu_result`. `csr_f`, `gr_we`, `dest` and `pc` pass through unchanged.
- Forwarding:
  - `fwd_we = ms_valid && gr_we`.
  - `fwd_block = ms_valid && res_from_mem && !ms_ready_go`.
  - `fwd_data = final_result`.
  - `fwd_dest = dest`.

## Timing
- After reset:
  - `ms_valid = 0`, state IDLE, `ms_bus_r = 0`, `rdata_buf = 0`.
  - `ms_allowin = 1`, `ms_to_ws_valid = 0`.
  - `ms_to_ws_bus = 0`, `ms_to_ds_fwd = 0`.
- Non-memory instruction: one cycle of latency. It is accepted at edge N and `ms_to_ws_valid` is high during cycle N+1.
- Load: `ms_to_ws_valid` is asserted combinationally in the `data_ok` cycle.
- Held response: `ms_to_ws_valid` stays high from the `data_ok` cycle until `ws_allowin`. The bus is stable while it waits.
- `ws_flush_pipe` has priority over acceptance and over `data_ok` capture.
- In DISCARD, `ms_allowin = 0`, so exactly one stale response is swallowed before a new request can be tracked.
- Reset mid-WAIT or mid-DISCARD: go to IDLE immediately. Any later stale `data_ok` is ignored because IDLE has no pending response.

## Test plan
- ALU op, `pc=0x1c000000`, `alu_result=0x12345678`, `ws_allowin=1` → next cycle `ms_to_ws_valid=1`, `final_result=0x12345678`, `fwd_block=0`.
- `ld.b`, `alu_result=...03`, `mem_sign=1`, `data_ok` 3 cycles later with `rdata=0x80FF0011` → `fwd_block=1` for 2 cycles, then `final_result=0xFFFFFF80`. Same case with `ld.hu` at `off=2` → `0x000080FF`.
- Load whose `data_ok` arrives with `ws_allowin=0` → HELD. Raise `ws_allowin` 2 cycles later → bus shows the captured word, state returns to IDLE.
- `ws_flush_pipe` in WAIT, then a new load offered → `ms_allowin=0` until the stale `data_ok`, which is dropped. The new load then completes with its own data.
- `ws_flush_pipe` in the same cycle as `es_to_ms_valid` → nothing is latched, `ms_to_ws_valid` stays 0.
- Reset asserted in WAIT with `data_ok` one cycle later → state IDLE, all outputs zero, no valid emitted.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: holds the execute result, waits for the data-SRAM
// response when a request was issued, aligns/extends load data and forwards to decode.
module mem_stage #(
  parameter int ES_W = 157,
  parameter int MS_W = 152
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_to_ms_valid,
  output logic            ms_allowin,
  input  logic [ES_W-1:0] es_to_ms_bus,
  input  logic            data_sram_data_ok,
  input  logic [31:0]     data_sram_rdata,
  input  logic            ws_allowin,
  output logic            ms_to_ws_valid,
  output logic [MS_W-1:0] ms_to_ws_bus,
  output logic [38:0]     ms_to_ds_fwd,
  input  logic            ws_flush_pipe,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on a clock edge where the producer's valid
  // and the consumer's allowin are both high; valid never depends on allowin
  // of the same stage, and a flush from write-back cancels any transfer.

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_HELD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t          state;
  logic            ms_valid;
  logic [ES_W-1:0] ms_bus_r;
  logic [31:0]     rdata_buf;

  logic [81:0] csr_f;
  logic        req_issued;
  logic        mem_sign;
  logic [1:0]  mem_size;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign csr_f        = ms_bus_r[156:75];
  assign req_issued   = ms_bus_r[74];
  assign mem_sign     = ms_bus_r[73];
  assign mem_size     = ms_bus_r[72:71];
  assign res_from_mem = ms_bus_r[70];
  assign gr_we        = ms_bus_r[69];
  assign dest         = ms_bus_r[68:64];
  assign alu_result   = ms_bus_r[63:32];
  assign pc           = ms_bus_r[31:0];

  logic es_req_issued;
  logic accept;
  logic need_resp;
  logic ms_ready_go;

  assign es_req_issued = es_to_ms_bus[74];
  assign need_resp     = ms_valid && req_issued;
  assign ms_ready_go   = !need_resp
                       || (state == S_WAIT && data_sram_data_ok)
                       || (state == S_HELD);
  assign ms_allowin    = (state != S_DISCARD)
                       && (!ms_valid || (ms_ready_go && ws_allowin));
  assign accept        = es_to_ms_valid && ms_allowin && !ws_flush_pipe;
  assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ws_flush_pipe) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_bus_r <= '0;
    end else if (accept) begin
      ms_bus_r <= es_to_ms_bus;
    end
  end

  // Response tracker; a newly accepted request overrides whatever the old
  // instruction's completion would have chosen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rdata_buf <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end
        S_WAIT: begin
          if (ws_flush_pipe) begin
            state <= data_sram_data_ok ? S_IDLE : S_DISCARD;
          end else if (data_sram_data_ok) begin
            if (ws_allowin) begin
              state <= S_IDLE;
            end else begin
              state     <= S_HELD;
              rdata_buf <= data_sram_rdata;
            end
          end
        end
        S_HELD: begin
          if (ws_allowin || ws_flush_pipe) state <= S_IDLE;
        end
        S_DISCARD: begin
          if (data_sram_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      if (accept && es_req_issued && !(state == S_IDLE && data_sram_data_ok)) begin
        state <= S_WAIT;
      end
    end
  end

  logic [31:0] load_src;
  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [31:0] aligned_load;
  logic [31:0] final_result;
  logic [1:0]  off;

  assign off = alu_result[1:0];

  always_comb begin
    load_src     = (state == S_HELD) ? rdata_buf : data_sram_rdata;
    byte_shift   = load_src >> {off, 3'b000};
    half_shift   = load_src >> {off[1], 4'b0000};
    aligned_load = load_src;
    case (mem_size)
      2'd0:    aligned_load = {{24{mem_sign & byte_shift[7]}}, byte_shift[7:0]};
      2'd1:    aligned_load = {{16{mem_sign & half_shift[15]}}, half_shift[15:0]};
      default: aligned_load = load_src;
    endcase
    final_result = res_from_mem ? aligned_load : alu_result;
  end

  assign ms_to_ws_bus = {csr_f, gr_we, dest, final_result, pc};

  logic fwd_we;
  logic fwd_block;

  assign fwd_we       = ms_valid && gr_we;
  assign fwd_block    = ms_valid && res_from_mem && !ms_ready_go;
  assign ms_to_ds_fwd = {fwd_we, dest, fwd_block, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors plus
// hand-written sequences for held responses, flush, discard and reset.
module tb_mem_stage;

  logic          clk = 1'b0;
  logic          reset;
  logic          es_to_ms_valid;
  logic          ms_allowin;
  logic [156:0]  es_to_ms_bus;
  logic          data_sram_data_ok;
  logic [31:0]   data_sram_rdata;
  logic          ws_allowin;
  logic          ms_to_ws_valid;
  logic [151:0]  ms_to_ws_bus;
  logic [38:0]   ms_to_ds_fwd;
  logic          ws_flush_pipe;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_fwd      (ms_to_ds_fwd),
    .ws_flush_pipe     (ws_flush_pipe),
    .dbg_state         (dbg_state)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic        gr_we;
    logic        res_mem;
    logic [1:0]  size;
    logic        sign;
    logic        req;
    int          delay;
    logic [31:0] rdata;
    logic [31:0] exp_final;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [81:0] mk_csr(input vec_t v);
    return {v.pc[17:0], v.alu, v.pc};
  endfunction

  function automatic logic [156:0] mk_bus(input vec_t v);
    return {mk_csr(v), v.req, v.sign, v.size, v.res_mem, v.gr_we, v.dest, v.alu, v.pc};
  endfunction

  function automatic logic [151:0] exp_ms_bus(input vec_t v);
    return {mk_csr(v), v.gr_we, v.dest, v.exp_final, v.pc};
  endfunction

  task automatic chk(input string nm, input logic [151:0] act, input logic [151:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    ws_flush_pipe     = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    es_to_ms_bus   = mk_bus(v);
    es_to_ms_valid = 1'b1;
    #4;
    chk({nm, "_allowin"}, ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus   = '0;
    if (v.req) begin
      for (int k = 1; k < v.delay; k++) begin
        #4;
        chk({nm, "_wait_valid"}, ms_to_ws_valid, 0);
        chk({nm, "_wait_block"}, ms_to_ds_fwd[32], v.res_mem);
        chk({nm, "_wait_we"}, ms_to_ds_fwd[38], v.gr_we);
        chk({nm, "_wait_state"}, dbg_state, 1);
        tick();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = v.rdata;
    end
    #4;
    chk({nm, "_valid"}, ms_to_ws_valid, 1);
    chk({nm, "_bus"}, ms_to_ws_bus, exp_ms_bus(v));
    chk({nm, "_fwd"}, ms_to_ds_fwd, {v.gr_we, v.dest, 1'b0, v.exp_final});
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    #4;
    chk({nm, "_after_valid"}, ms_to_ws_valid, 0);
    chk({nm, "_after_state"}, dbg_state, 0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    vec_t v2;
    vecs[0] = '{32'h1c000000, 32'h12345678, 5'd5,  1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 0, 32'h0,        32'h12345678};
    vecs[1] = '{32'h1c000004, 32'h00001003, 5'd6,  1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 3, 32'h80FF0011, 32'hFFFFFF80};
    vecs[2] = '{32'h1c000008, 32'h00001002, 5'd7,  1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3, 32'h80FF0011, 32'h000080FF};
    vecs[3] = '{32'h1c00000c, 32'h00001001, 5'd8,  1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 2, 32'h1234A5C6, 32'h000000A5};
    vecs[4] = '{32'h1c000010, 32'h00001001, 5'd9,  1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 1, 32'h1234A5C6, 32'hFFFFFFA5};
    vecs[5] = '{32'h1c000014, 32'h00001000, 5'd10, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2, 32'h1234A5C6, 32'hFFFFA5C6};
    vecs[6] = '{32'h1c000018, 32'h00001000, 5'd11, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[7] = '{32'h1c00001c, 32'h00002000, 5'd0,  1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2, 32'h0,        32'h00002000};
    vecs[8] = '{32'h1c000020, 32'h00001002, 5'd12, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1, 32'h7FFF0000, 32'h00007FFF};
    vecs[9] = '{32'h1c000024, 32'hFFFFFFFF, 5'd31, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 0, 32'h0,        32'hFFFFFFFF};

    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #4;
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_bus", ms_to_ws_bus, 0);
    chk("rst_fwd", ms_to_ds_fwd, 0);
    chk("rst_state", dbg_state, 0);
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Response arrives while write-back stalls; captured word must be replayed.
    v = '{32'h1c000100, 32'h00003003, 5'd13, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 2, 32'h80FF0011, 32'hFFFFFF80};
    es_to_ms_bus = mk_bus(v);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    #4;
    chk("held_wait_state", dbg_state, 1);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = v.rdata;
    ws_allowin = 1'b0;
    #4;
    chk("held_ok_valid", ms_to_ws_valid, 1);
    chk("held_ok_final", ms_to_ws_bus[63:32], 32'hFFFFFF80);
    chk("held_ok_allowin", ms_allowin, 0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      #4;
      chk("held_state", dbg_state, 2);
      chk("held_valid", ms_to_ws_valid, 1);
      chk("held_bus", ms_to_ws_bus, exp_ms_bus(v));
      chk("held_allowin", ms_allowin, 0);
      tick();
    end
    ws_allowin = 1'b1;
    #4;
    chk("held_rel_valid", ms_to_ws_valid, 1);
    chk("held_rel_bus", ms_to_ws_bus, exp_ms_bus(v));
    chk("held_rel_allowin", ms_allowin, 1);
    tick();
    #4;
    chk("held_end_state", dbg_state, 0);
    chk("held_end_valid", ms_to_ws_valid, 0);
    tick();

    // Flush while waiting: stale response is swallowed before the next load.
    v = '{32'h1c000200, 32'h00004000, 5'd14, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1, 32'h11111111, 32'h11111111};
    v2 = '{32'h1c000204, 32'h00004004, 5'd15, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1, 32'h22222222, 32'h22222222};
    es_to_ms_bus = mk_bus(v);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    ws_flush_pipe = 1'b1;
    #4;
    chk("fl_wait_state", dbg_state, 1);
    chk("fl_flush_valid", ms_to_ws_valid, 0);
    tick();
    ws_flush_pipe = 1'b0;
    es_to_ms_bus = mk_bus(v2);
    es_to_ms_valid = 1'b1;
    #4;
    chk("fl_disc_state", dbg_state, 3);
    chk("fl_disc_allowin0", ms_allowin, 0);
    tick();
    #4;
    chk("fl_disc_allowin1", ms_allowin, 0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h11111111;
    #4;
    chk("fl_stale_allowin", ms_allowin, 0);
    chk("fl_stale_valid", ms_to_ws_valid, 0);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    #4;
    chk("fl_idle_state", dbg_state, 0);
    chk("fl_idle_allowin", ms_allowin, 1);
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    #4;
    chk("fl_new_state", dbg_state, 1);
    chk("fl_new_wait_valid", ms_to_ws_valid, 0);
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h22222222;
    #4;
    chk("fl_new_valid", ms_to_ws_valid, 1);
    chk("fl_new_bus", ms_to_ws_bus, exp_ms_bus(v2));
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    #4;
    chk("fl_new_end_state", dbg_state, 0);
    tick();

    // Flush coinciding with an offered instruction: nothing is latched.
    v = '{32'h1c000300, 32'h0000ABCD, 5'd16, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 0, 32'h0, 32'h0000ABCD};
    es_to_ms_bus = mk_bus(v);
    es_to_ms_valid = 1'b1;
    ws_flush_pipe = 1'b1;
    #4;
    chk("flacc_valid_now", ms_to_ws_valid, 0);
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_flush_pipe = 1'b0;
    #4;
    chk("flacc_valid", ms_to_ws_valid, 0);
    chk("flacc_fwd_we", ms_to_ds_fwd[38], 0);
    chk("flacc_pc", ms_to_ws_bus[31:0], v2.pc);
    tick();

    // Reset in the middle of a wait; the late response must be ignored.
    v = '{32'h1c000400, 32'h00005000, 5'd17, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 2, 32'hCAFEBABE, 32'hCAFEBABE};
    es_to_ms_bus = mk_bus(v);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    reset = 1'b1;
    #4;
    chk("rw_state_before", dbg_state, 1);
    tick();
    reset = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFEBABE;
    #4;
    chk("rw_state", dbg_state, 0);
    chk("rw_valid", ms_to_ws_valid, 0);
    chk("rw_bus", ms_to_ws_bus, 0);
    chk("rw_fwd", ms_to_ds_fwd, 0);
    chk("rw_allowin", ms_allowin, 1);
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    #4;
    chk("rw_end_state", dbg_state, 0);
    chk("rw_end_valid", ms_to_ws_valid, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
